// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and M/W operand forwarding
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            StallD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE
);

    logic            ALUSrcE;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic            hazard;
    logic            bubble;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // A load in E whose destination feeds the D instruction cannot forward in time.
    assign hazard = ValidE && (ResultSrcE == 2'b01) && (RdE != 5'd0) && ValidD &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
    assign StallD = hazard && !FlushE;
    assign bubble = FlushE || hazard;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RdE         <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
        end else begin
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD;
            MemWriteE   <= MemWriteD;
            BranchE     <= BranchD;
            JumpE       <= JumpD;
            ALUSrcE     <= ALUSrcD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            RdE         <= RdD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= ImmExtD;
            PCE         <= PCD;
        end
    end

    // The younger M result wins over W; x0 is never forwarded.
    always_comb begin
        fwd_a = RD1E;
        if ((Rs1E != 5'd0) && RegWriteM && (RdM == Rs1E))
            fwd_a = ALUResultM;
        else if ((Rs1E != 5'd0) && RegWriteW && (RdW == Rs1E))
            fwd_a = ResultW;
    end

    always_comb begin
        fwd_b = RD2E;
        if ((Rs2E != 5'd0) && RegWriteM && (RdM == Rs2E))
            fwd_b = ALUResultM;
        else if ((Rs2E != 5'd0) && RegWriteW && (RdW == Rs2E))
            fwd_b = ResultW;
    end

    assign SrcAE      = fwd_a;
    assign WriteDataE = fwd_b;
    assign SrcBE      = ALUSrcE ? ImmExtE : fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;

    // {valid, regwrite, memwrite, branch, jump, alusrc, resultsrc[1:0], aluctl[2:0]}
    localparam logic [10:0] C_ALU   = 11'b1_1_0_0_0_0_00_000;
    localparam logic [10:0] C_BR    = 11'b1_0_0_1_0_0_00_001;
    localparam logic [10:0] C_IMM   = 11'b1_1_0_0_0_1_00_010;
    localparam logic [10:0] C_LOAD  = 11'b1_1_0_0_0_1_01_000;
    localparam logic [10:0] C_STORE = 11'b1_0_1_0_0_1_00_000;
    localparam logic [10:0] C_INV   = 11'b0_1_0_0_0_0_00_000;

    typedef struct {
        logic [10:0] ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc;
        logic        flush;
        logic        fm;
        logic [4:0]  rdm;
        logic [31:0] alum;
        logic        fw;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic        exp_stall;
        logic        exp_cap;
        logic [31:0] exp_a, exp_b, exp_wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD;
    logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] ALUResultM, ResultW;
    logic        FlushE;
    logic        StallD, ValidE, RegWriteE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;

    int tests = 0;
    int failed = 0;
    vec_t vecs[$];

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .JumpD(JumpD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .FlushE(FlushE),
        .StallD(StallD), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
        .PCE(PCE), .ImmExtE(ImmExtE)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ctrl_e();
        return {23'd0, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_d(input logic [10:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [31:0] pc);
        {ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, ALUControlD} = c;
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
        RD1D = rd1; RD2D = rd2; ImmExtD = imm; PCD = pc;
    endtask

    task automatic drive_fwd(input logic fm, input logic [4:0] rdm, input logic [31:0] alum,
                             input logic fw, input logic [4:0] rdw, input logic [31:0] resw);
        RegWriteM = fm; RdM = rdm; ALUResultM = alum;
        RegWriteW = fw; RdW = rdw; ResultW = resw;
    endtask

    function automatic vec_t mk(input logic [10:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic flush,
                                input logic fm, input logic [4:0] rdm, input logic [31:0] alum,
                                input logic fw, input logic [4:0] rdw, input logic [31:0] resw,
                                input logic st, input logic cap, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] wd);
        vec_t v;
        v.ctrl = c; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc; v.flush = flush;
        v.fm = fm; v.rdm = rdm; v.alum = alum; v.fw = fw; v.rdw = rdw; v.resw = resw;
        v.exp_stall = st; v.exp_cap = cap; v.exp_a = a; v.exp_b = b; v.exp_wd = wd;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        FlushE = 1'b0;
        drive_d(11'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset ctrl", ctrl_e(), 32'd0);
        check("reset stall", {31'd0, StallD}, 32'd0);
        check("reset srca", SrcAE, 32'd0);
        check("reset srcb", SrcBE, 32'd0);
        check("reset pc", PCE, 32'd0);

        //        ctrl     rs1 rs2 rd  rd1            rd2          imm            pc          fl  fm rdm alum           fw rdw resw           st cap a              b              wd
        vecs.push_back(mk(C_ALU,   1, 2, 5, 32'h5,        32'h7,       32'h10,        32'h100, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h5,        32'h7,        32'h7));
        vecs.push_back(mk(C_BR,    3, 0, 6, 32'h11,       32'h22,      32'h20,        32'h104, 0, 1, 3, 32'hAA,       1, 3, 32'hBB,       0, 1, 32'hAA,       32'h22,       32'h22));
        vecs.push_back(mk(C_IMM,   0, 7, 8, 32'h3,        32'h9,       32'hFFFFFFF0,  32'h108, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h3,        32'hFFFFFFF0, 32'h9));
        vecs.push_back(mk(C_LOAD,  8, 9, 4, 32'h100,      32'h0,       32'h8,         32'h10C, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h100,      32'h8,        32'h0));
        vecs.push_back(mk(C_ALU,   1, 4, 10, 32'h55,      32'h66,      32'h0,         32'h110, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(C_ALU,   1, 4, 10, 32'h55,      32'h66,      32'h0,         32'h110, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h55,       32'h66,       32'h66));
        vecs.push_back(mk(C_ALU,   0, 0, 11, 32'h12,      32'h34,      32'h0,         32'h114, 0, 1, 0, 32'hDEAD,     1, 0, 32'hBEEF,     0, 1, 32'h12,       32'h34,       32'h34));
        vecs.push_back(mk(C_STORE, 6, 5, 0, 32'h1,        32'h9,       32'h4,         32'h118, 0, 1, 6, 32'hC0,       1, 5, 32'h77,       0, 1, 32'hC0,       32'h4,        32'h77));
        vecs.push_back(mk(C_LOAD,  0, 0, 4, 32'h200,      32'h0,       32'h0,         32'h11C, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h200,      32'h0,        32'h0));
        vecs.push_back(mk(C_ALU,   4, 0, 12, 32'h1,       32'h2,       32'h0,         32'h120, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(C_LOAD,  0, 0, 4, 32'h300,      32'h0,       32'h4,         32'h124, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h300,      32'h4,        32'h0));
        vecs.push_back(mk(C_LOAD,  4, 0, 7, 32'h400,      32'h0,       32'h8,         32'h128, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(C_LOAD,  4, 0, 7, 32'h400,      32'h0,       32'h8,         32'h128, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h400,      32'h8,        32'h0));
        vecs.push_back(mk(C_ALU,   2, 7, 13, 32'h5,       32'h6,       32'h0,         32'h12C, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(C_LOAD,  0, 0, 3, 32'h500,      32'h0,       32'h0,         32'h130, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h500,      32'h0,        32'h0));
        vecs.push_back(mk(C_INV,   3, 3, 14, 32'h66,      32'h77,      32'h0,         32'h134, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h66,       32'h77,       32'h77));
        vecs.push_back(mk(C_LOAD,  0, 0, 0, 32'h700,      32'h0,       32'h0,         32'h138, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h700,      32'h0,        32'h0));
        vecs.push_back(mk(C_ALU,   0, 0, 1, 32'h1,        32'h2,       32'h0,         32'h13C, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h1,        32'h2,        32'h2));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive_d(v.ctrl, v.rs1, v.rs2, v.rd, v.rd1, v.rd2, v.imm, v.pc);
            FlushE = v.flush;
            drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            #1;
            check($sformatf("v%0d stall", i), {31'd0, StallD}, {31'd0, v.exp_stall});
            @(posedge clk);
            #1;
            FlushE = 1'b0;
            drive_fwd(v.fm, v.rdm, v.alum, v.fw, v.rdw, v.resw);
            #1;
            check($sformatf("v%0d ctrl", i), ctrl_e(),
                  v.exp_cap ? {23'd0, v.ctrl[10:6], v.ctrl[4:0]} : 32'd0);
            check($sformatf("v%0d rde", i), {27'd0, RdE}, v.exp_cap ? {27'd0, v.rd} : 32'd0);
            check($sformatf("v%0d srca", i), SrcAE, v.exp_a);
            check($sformatf("v%0d srcb", i), SrcBE, v.exp_b);
            check($sformatf("v%0d wdata", i), WriteDataE, v.exp_wd);
            check($sformatf("v%0d pce", i), PCE, v.exp_cap ? v.pc : 32'd0);
            check($sformatf("v%0d imme", i), ImmExtE, v.exp_cap ? v.imm : 32'd0);
        end

        // Forwarding priority on one captured instruction.
        drive_d(C_ALU, 5'd3, 5'd3, 5'd9, 32'h11, 32'h22, 32'h0, 32'h200);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        drive_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        #1;
        check("prio m over w a", SrcAE, 32'hAA);
        check("prio m over w b", WriteDataE, 32'hAA);
        drive_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        #1;
        check("prio w only", SrcAE, 32'hBB);
        drive_fwd(1'b0, 5'd3, 32'hAA, 1'b0, 5'd3, 32'hBB);
        #1;
        check("prio none", SrcAE, 32'h11);
        drive_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd3, 32'hBB);
        #1;
        check("prio m miss", SrcBE, 32'hBB);
        drive_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset while a valid store sits in E.
        drive_d(C_STORE, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h4, 32'h204);
        @(posedge clk);
        #1;
        check("store in e", {31'd0, MemWriteE}, 32'd1);
        drive_d(C_LOAD, 5'd0, 5'd0, 5'd5, 32'h99, 32'h98, 32'h97, 32'h208);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive_d(11'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check("rst store ctrl", ctrl_e(), 32'd0);
        check("rst store srca", SrcAE, 32'd0);
        check("rst store srcb", SrcBE, 32'd0);
        check("rst store wdata", WriteDataE, 32'd0);
        check("rst store pc", PCE, 32'd0);
        check("rst store imm", ImmExtE, 32'd0);
        check("rst store stall", {31'd0, StallD}, 32'd0);

        // Reset while a load-use stall is pending.
        drive_d(C_LOAD, 5'd0, 5'd0, 5'd4, 32'h10, 32'h0, 32'h0, 32'h300);
        @(posedge clk);
        #1;
        drive_d(C_ALU, 5'd4, 5'd0, 5'd6, 32'h20, 32'h30, 32'h0, 32'h304);
        #1;
        check("pre-rst stall", {31'd0, StallD}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive_d(11'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check("rst stall ctrl", ctrl_e(), 32'd0);
        check("rst stall srca", SrcAE, 32'd0);
        check("rst stall rde", {27'd0, RdE}, 32'd0);
        check("rst stall stall", {31'd0, StallD}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; all data ports below are XLEN wide unless stated.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD  in  1 each  decode-stage instruction valid and controls.
REQ-005 ResultSrcD  in  2  writeback select; 2'b01 = load.
REQ-006 ALUControlD  in  3  ALU opcode, same encoding the ALU consumes.
REQ-007 RD1D, RD2D, ImmExtD, PCD  in  XLEN  register-file reads, extended immediate, PC.
REQ-008 Rs1D, Rs2D, RdD  in  5 each  source/destination register indices.
REQ-009 RdM, RdW  in  5; RegWriteM, RegWriteW  in  1; ALUResultM, ResultW  in  XLEN  forwarding sources.
REQ-010 FlushE  in  1  taken branch/jump; kill the instruction entering E.
REQ-011 StallD  out  1  combinational load-use stall request to PC/IF-ID registers.
REQ-012 ValidE, RegWriteE, MemWriteE, BranchE, JumpE  out  1; ResultSrcE  out  2; ALUControlE  out  3; RdE  out  5  registered controls.
REQ-013 SrcAE, SrcBE  out  XLEN  ALU operands; WriteDataE  out  XLEN  store data; PCE, ImmExtE  out  XLEN  registered.

Function
REQ-014 E-register update priority each edge: reset > FlushE > load-use bubble > capture of D fields.
REQ-015 Capture: every D-suffixed input latched into its E register (Rs1E, Rs2E internal), 1-cycle latency.
REQ-016 Bubble (flush or load-use): ValidE, RegWriteE, MemWriteE, BranchE, JumpE = 0; ResultSrcE = 2'b00; ALUControlE = 3'b000; RdE, Rs1E, Rs2E = 0; data registers = 0.
REQ-017 Load-use hazard = ValidE & (ResultSrcE==2'b01) & (RdE!=0) & ValidD & ((RdE==Rs1D) | (RdE==Rs2D)).
REQ-018 StallD = hazard & ~FlushE; combinational, same cycle as hazard.
REQ-019 Forward A (combinational): if Rs1E!=0 & RegWriteM & RdM==Rs1E -> ALUResultM; else if Rs1E!=0 & RegWriteW & RdW==Rs1E -> ResultW; else RD1E.
REQ-020 Forward B: identical rule on Rs2E/RD2E; M stage wins when both M and W match.
REQ-021 SrcAE = forwarded A; WriteDataE = forwarded B; SrcBE = ALUSrcE ? ImmExtE : forwarded B.
REQ-022 Index 0 never forwarded, even when RegWriteM/W asserted with Rd=0.
REQ-023 Load-use stall lasts exactly one cycle per hazard: the bubble clears ResultSrcE, so hazard deasserts next cycle; back-to-back loads each produce one bubble.
REQ-024 FlushE and hazard same cycle: bubble inserted, StallD = 0.
REQ-025 No internal state beyond the E registers; no counters carried across reset.

Reset
REQ-026 On reset edge all E registers take bubble values (REQ-016); first cycle after reset StallD = 0, SrcAE = 0 unless forwarded from M/W inputs.
REQ-027 Reset asserted mid-stall overrides the pending bubble/capture; D inputs that edge are discarded.

Verification
REQ-028 Capture: ValidD=1, RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=000, Rs1D=1, Rs2D=2, no forwarding -> next cycle SrcAE=5, SrcBE=7, ValidE=1.
REQ-029 Forwarding priority: Rs1E=3, RegWriteM=1 RdM=3 ALUResultM=0xAA, RegWriteW=1 RdW=3 ResultW=0xBB -> SrcAE=0xAA; drop RegWriteM -> SrcAE=0xBB; Rs1E=0 -> SrcAE=RD1E.
REQ-030 Load-use: E holds load RdE=4; D has Rs2D=4, ValidD=1 -> StallD=1 that cycle; next cycle ValidE=0, RegWriteE=0, StallD=0; following cycle D instruction captured.
REQ-031 Flush vs hazard: same setup as REQ-030 plus FlushE=1 -> StallD=0, next cycle bubble.
REQ-032 Immediate path: ALUSrcD=1, ImmExtD=0xFFFFFFF0, RD2D=9 -> SrcBE=0xFFFFFFF0, WriteDataE=9.
REQ-033 Reset mid-operation: valid store in E, assert reset one cycle -> MemWriteE=0, ValidE=0, all data outputs 0 next cycle.
